// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and FSM state type for the 64-bit LFSR scrambler pair
//
// Contents:
//   LFSR_W             word / keystream width (64)
//   LFSR_DEFAULT_POLY  feedback tap mask for x^64+x^63+x^61+x^60+1
//   LFSR_DEFAULT_SEED  keystream used when an all-zero seed is rejected
//   lfsr_state_e       UNSEEDED / RUN
package lfsr_pkg;

   localparam int unsigned LFSR_W = 64;

   localparam logic [LFSR_W-1:0] LFSR_DEFAULT_POLY = 64'hD800_0000_0000_0000;
   localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 64'h0000_0000_0000_0001;

   typedef enum logic {
      ST_UNSEEDED = 1'b0,
      ST_RUN      = 1'b1
   } lfsr_state_e;

endpackage : lfsr_pkg

// File: rtl/lfsr_64_advance.sv
// rtl/lfsr_64_advance.sv - combinational 64-step advance of a Fibonacci LFSR state
//
// Parameters:
//   POLY   feedback tap mask; one step is fb = ^(k & POLY), k = {k[62:0], fb}
// Ports:
//   k_in   current keystream state
//   k_out  state after exactly 64 single steps
module lfsr_64_advance
   import lfsr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] POLY = LFSR_DEFAULT_POLY
) (
   input  logic [LFSR_W-1:0] k_in,
   output logic [LFSR_W-1:0] k_out
);

   // Unrolled by synthesis into an XOR network; each bit of k_out is a
   // fixed parity of k_in bits.
   always_comb begin
      logic [LFSR_W-1:0] k;
      k = k_in;
      for (int i = 0; i < LFSR_W; i++) begin
         k = {k[LFSR_W-2:0], ^(k & POLY)};
      end
      k_out = k;
   end

endmodule : lfsr_64_advance

// File: rtl/lfsr_64_bit.sv
// rtl/lfsr_64_bit.sv - 64-bit additive scrambler, keystream partner of lfsr_64_descrambler
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   cs         data_in carries a plain word this cycle
//   data_in    plain word
//   seed_load  load seed_in as keystream state (zero seed -> DEFAULT_SEED)
//   seed_in    seed
//   data_out   scrambled word (data_in ^ K), one cycle latency
//   out_valid  data_out is new this cycle
module lfsr_64_bit
   import lfsr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] POLY         = LFSR_DEFAULT_POLY,
   parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic [LFSR_W-1:0] data_in,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   output logic [LFSR_W-1:0] data_out,
   output logic              out_valid
);

   logic [LFSR_W-1:0] k_q;
   logic [LFSR_W-1:0] k_adv;
   logic              seeded_q;

   lfsr_64_advance #(.POLY(POLY)) u_adv (
      .k_in  (k_q),
      .k_out (k_adv)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q       <= '0;
         seeded_q  <= 1'b0;
         data_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (seed_load) begin
            k_q      <= (seed_in == '0) ? DEFAULT_SEED : seed_in;
            seeded_q <= 1'b1;
         end else if (cs && seeded_q) begin
            data_out  <= data_in ^ k_q;
            out_valid <= 1'b1;
            k_q       <= (k_adv == '0) ? DEFAULT_SEED : k_adv;
         end
      end
   end

endmodule : lfsr_64_bit

// File: rtl/lfsr_64_descrambler.sv
// rtl/lfsr_64_descrambler.sv - 64-bit additive descrambler with seed handling and drop reporting
//
// Optional feature macro: DESCRAMBLER_WORD_CNT_EN (adds word_cnt output and counter)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   cs         data_in carries a scrambled word this cycle
//   data_in    scrambled word
//   seed_load  load seed_in as keystream state; has priority over cs
//   seed_in    seed (zero is rejected: DEFAULT_SEED is used and err pulses)
//   data_out   descrambled word, one cycle latency, holds when idle
//   out_valid  1-cycle pulse when data_out is new
//   state_out  1 in RUN, 0 in UNSEEDED
//   err        1-cycle pulse on dropped word or rejected zero seed
//   word_cnt   (DESCRAMBLER_WORD_CNT_EN only) words delivered since last seed_load
module lfsr_64_descrambler
   import lfsr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] POLY         = LFSR_DEFAULT_POLY,
   parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic [LFSR_W-1:0] data_in,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   output logic [LFSR_W-1:0] data_out,
   output logic              out_valid,
   output logic              state_out,
   output logic              err
`ifdef DESCRAMBLER_WORD_CNT_EN
   ,
   output logic [31:0]       word_cnt
`endif
);

   lfsr_state_e       state_q, state_d;
   logic [LFSR_W-1:0] k_q, k_d;
   logic [LFSR_W-1:0] k_adv;
   logic [LFSR_W-1:0] dout_d;
   logic              valid_d;
   logic              err_d;

   lfsr_64_advance #(.POLY(POLY)) u_adv (
      .k_in  (k_q),
      .k_out (k_adv)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_UNSEEDED;
         k_q       <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         data_out  <= dout_d;
         out_valid <= valid_d;
         err       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      dout_d  = data_out;
      valid_d = 1'b0;
      err_d   = 1'b0;

      if (seed_load) begin
         // Seed wins over a coincident word; a zero seed and a dropped word
         // in the same cycle still produce only one err pulse.
         state_d = ST_RUN;
         if (seed_in == '0) begin
            k_d   = DEFAULT_SEED;
            err_d = 1'b1;
         end else begin
            k_d = seed_in;
         end
         if (cs) begin
            err_d = 1'b1;
         end
      end else if (cs) begin
         if (state_q == ST_RUN) begin
            dout_d  = data_in ^ k_q;
            valid_d = 1'b1;
            // Guard against a non-primitive POLY collapsing the state to zero.
            k_d     = (k_adv == '0) ? DEFAULT_SEED : k_adv;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   assign state_out = (state_q == ST_RUN);

`ifdef DESCRAMBLER_WORD_CNT_EN
   // Counts in the same cycle out_valid rises, so word_cnt already includes
   // the word being presented; wraps naturally at 32 bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_cnt <= '0;
      end else if (seed_load) begin
         word_cnt <= '0;
      end else if (valid_d) begin
         word_cnt <= word_cnt + 32'd1;
      end
   end
`endif

endmodule : lfsr_64_descrambler

// File: tb/tb_lfsr_64_descrambler.sv
// tb/tb_lfsr_64_descrambler.sv - directed self-checking bench for lfsr_64_descrambler
module tb_lfsr_64_descrambler;

   logic        clk;
   logic        rst;
   logic        cs;
   logic [63:0] data_in;
   logic        seed_load;
   logic [63:0] seed_in;
   logic [63:0] data_out;
   logic        out_valid;
   logic        state_out;
   logic        err;
`ifdef DESCRAMBLER_WORD_CNT_EN
   logic [31:0] word_cnt;
`endif

   logic        s_cs;
   logic [63:0] s_data_in;
   logic        s_seed_load;
   logic [63:0] s_seed_in;
   logic [63:0] s_data_out;
   logic        s_out_valid;

   int total;
   int bad;

   lfsr_64_descrambler dut (
      .clk       (clk),
      .rst       (rst),
      .cs        (cs),
      .data_in   (data_in),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .data_out  (data_out),
      .out_valid (out_valid),
      .state_out (state_out),
      .err       (err)
`ifdef DESCRAMBLER_WORD_CNT_EN
      ,
      .word_cnt  (word_cnt)
`endif
   );

   lfsr_64_bit u_scr (
      .clk       (clk),
      .rst       (rst),
      .cs        (s_cs),
      .data_in   (s_data_in),
      .seed_load (s_seed_load),
      .seed_in   (s_seed_in),
      .data_out  (s_data_out),
      .out_valid (s_out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 ns after the next rising edge; outputs are sampled there
   // and inputs for the following edge are driven there.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cs          = 1'b0;
      data_in     = '0;
      seed_load   = 1'b0;
      seed_in     = '0;
      s_cs        = 1'b0;
      s_data_in   = '0;
      s_seed_load = 1'b0;
      s_seed_in   = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      cycle();
      cycle();
      total++; if (data_out !== 64'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=%h", data_out, 64'h0); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (state_out !== 1'b0) begin bad++; $display("FAIL reset_state_out got=%b exp=0", state_out); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      rst = 1'b1;
      cycle();
   endtask

   task automatic test_unseeded_drop();
      cs = 1'b1; data_in = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle();
      cs = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL unseeded_err got=%b exp=1", err); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL unseeded_valid got=%b exp=0", out_valid); end
      total++; if (data_out !== 64'h0) begin bad++; $display("FAIL unseeded_data got=%h exp=%h", data_out, 64'h0); end
      total++; if (state_out !== 1'b0) begin bad++; $display("FAIL unseeded_state got=%b exp=0", state_out); end
      cycle();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL unseeded_err_pulse got=%b exp=0", err); end
   endtask

   task automatic test_basic();
      seed_load = 1'b1; seed_in = 64'h1;
      cycle();
      seed_load = 1'b0; seed_in = '0;
      total++; if (state_out !== 1'b1) begin bad++; $display("FAIL seed_state got=%b exp=1", state_out); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL seed_err got=%b exp=0", err); end
      cs = 1'b1; data_in = 64'h0;
      cycle();
      cs = 1'b0;
      total++; if (data_out !== 64'h1) begin bad++; $display("FAIL basic_data got=%h exp=%h", data_out, 64'h1); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      total++; if (state_out !== 1'b1) begin bad++; $display("FAIL basic_state got=%b exp=1", state_out); end
      cycle();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
      total++; if (data_out !== 64'h1) begin bad++; $display("FAIL idle_hold got=%h exp=%h", data_out, 64'h1); end
      // 64 steps from K=1 with taps 63,62,60,59 land on bits {4,3,1,0}.
      cs = 1'b1; data_in = 64'h0;
      cycle();
      cs = 1'b0;
      total++; if (data_out !== 64'h1B) begin bad++; $display("FAIL second_key got=%h exp=%h", data_out, 64'h1B); end
   endtask

   task automatic test_round_trip();
      logic [63:0] plain [2];
      logic [63:0] scr   [2];
      logic [63:0] scr_exp [2];
      plain[0] = 64'h6261_6E6A_6F69_6E67; plain[1] = 64'h0;
      scr_exp[0] = 64'h6261_6E6A_6F69_6E66; scr_exp[1] = 64'h1B;
      s_seed_load = 1'b1; s_seed_in = 64'h1;
      seed_load   = 1'b1; seed_in   = 64'h1;
      cycle();
      s_seed_load = 1'b0; seed_load = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_cs = 1'b1; s_data_in = plain[i];
         cycle();
         s_cs = 1'b0;
         scr[i] = s_data_out;
         total++; if (s_data_out !== scr_exp[i] || s_out_valid !== 1'b1) begin bad++; $display("FAIL scramble_%0d got=%h exp=%h", i, s_data_out, scr_exp[i]); end
      end
      for (int i = 0; i < 2; i++) begin
         cs = 1'b1; data_in = scr[i];
         cycle();
         cs = 1'b0;
         total++; if (data_out !== plain[i] || out_valid !== 1'b1) begin bad++; $display("FAIL recover_%0d got=%h exp=%h", i, data_out, plain[i]); end
      end
   endtask

   task automatic test_zero_seed();
      seed_load = 1'b1; seed_in = 64'h0;
      cycle();
      seed_load = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL zero_seed_err got=%b exp=1", err); end
      total++; if (state_out !== 1'b1) begin bad++; $display("FAIL zero_seed_state got=%b exp=1", state_out); end
      cs = 1'b1; data_in = 64'h0;
      cycle();
      cs = 1'b0;
      total++; if (data_out !== 64'h1) begin bad++; $display("FAIL zero_seed_data got=%h exp=%h", data_out, 64'h1); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL zero_seed_err_clear got=%b exp=0", err); end
   endtask

   task automatic test_seed_priority();
      // data_out is 64'h1 from the previous test and must hold.
      seed_load = 1'b1; seed_in = 64'h0; cs = 1'b1; data_in = 64'h5555_5555_5555_5555;
      cycle();
      seed_load = 1'b0; cs = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL prio_err got=%b exp=1", err); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prio_valid got=%b exp=0", out_valid); end
      total++; if (data_out !== 64'h1) begin bad++; $display("FAIL prio_hold got=%h exp=%h", data_out, 64'h1); end
      cycle();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL prio_single_pulse got=%b exp=0", err); end
      seed_load = 1'b1; seed_in = 64'hF0; cs = 1'b1; data_in = 64'h5555_5555_5555_5555;
      cycle();
      seed_load = 1'b0; cs = 1'b1; data_in = 64'h0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL prio2_err got=%b exp=1", err); end
      cycle();
      cs = 1'b0;
      total++; if (data_out !== 64'hF0) begin bad++; $display("FAIL prio2_first_key got=%h exp=%h", data_out, 64'hF0); end
   endtask

   task automatic test_mid_reset();
      seed_load = 1'b1; seed_in = 64'h1;
      cycle();
      seed_load = 1'b0;
      cs = 1'b1; data_in = 64'hA5A5_0000_0000_0000;
      cycle();
      cs = 1'b0;
      total++; if (out_valid !== 1'b1 || data_out !== 64'hA5A5_0000_0000_0001) begin bad++; $display("FAIL pre_reset got=%h/%b exp=%h/1", data_out, out_valid, 64'hA5A5_0000_0000_0001); end
      #2 rst = 1'b0;
      #1;
      total++; if (data_out !== 64'h0) begin bad++; $display("FAIL async_data got=%h exp=%h", data_out, 64'h0); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", out_valid); end
      total++; if (state_out !== 1'b0) begin bad++; $display("FAIL async_state got=%b exp=0", state_out); end
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      cs = 1'b1; data_in = 64'h1234;
      cycle();
      cs = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL post_reset_err got=%b exp=1", err); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
   endtask

`ifdef DESCRAMBLER_WORD_CNT_EN
   task automatic test_word_cnt();
      seed_load = 1'b1; seed_in = 64'h77;
      cycle();
      seed_load = 1'b0;
      total++; if (word_cnt !== 32'd0) begin bad++; $display("FAIL cnt_seed got=%0d exp=0", word_cnt); end
      for (int i = 0; i < 3; i++) begin
         cs = 1'b1; data_in = 64'(i);
         cycle();
      end
      cs = 1'b0;
      cycle();
      total++; if (word_cnt !== 32'd3) begin bad++; $display("FAIL cnt_three got=%0d exp=3", word_cnt); end
      seed_load = 1'b1; seed_in = 64'h1;
      cycle();
      seed_load = 1'b0;
      total++; if (word_cnt !== 32'd0) begin bad++; $display("FAIL cnt_clear got=%0d exp=0", word_cnt); end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle_inputs();
      #2;
      test_reset();
      test_unseeded_drop();
      test_basic();
      test_round_trip();
      test_zero_seed();
      test_seed_priority();
      test_mid_reset();
`ifdef DESCRAMBLER_WORD_CNT_EN
      test_word_cnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_lfsr_64_descrambler
